// File: rtl/alu_uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// alu_uart_frame_ctrl
//   Framed command controller sitting between a UART FIFO pair and an ALU.
//   A frame on rx is: DATA_BYTES bytes of operand A (LSB first), DATA_BYTES
//   bytes of operand B (LSB first), then one opcode byte. The operands and
//   opcode are presented to the ALU for one EXEC cycle. The result is latched
//   and returned on tx LSB first, honouring tx back-pressure. A partial frame
//   that stalls for TIMEOUT_CYCLES idle cycles is discarded.
//
//   Optional feature macro: STATUS_BYTE_EN
//     defined   : tx frame = result bytes + one status byte {6'b0, zero, carry}
//     undefined : tx frame = result bytes only
//
// Ports
//   i_clock       system clock
//   i_reset_n     asynchronous active-low reset
//   i_rx_data     rx FIFO head byte (first-word fall-through)
//   i_rx_empty    rx FIFO empty
//   o_rd_uart     rx pop strobe, one cycle per consumed byte
//   o_tx_data     byte to tx FIFO
//   o_wr_uart     tx push strobe
//   i_tx_full     tx FIFO full
//   o_alu_a       operand A to ALU
//   o_alu_b       operand B to ALU
//   o_alu_op      opcode to ALU
//   i_alu_result  ALU combinational result
//   i_alu_carry   ALU carry
//   o_result      last latched result
//   o_carry       carry of last result
//   o_zero        last result == 0
//   o_busy        high unless idle in RX_A with no byte of a frame received
//   o_done        one-cycle pulse after the last tx byte of a frame is pushed
//   o_frame_err   one-cycle pulse when a stalled partial frame is discarded
// -----------------------------------------------------------------------------
module alu_uart_frame_ctrl #(
  parameter int DATA_BYTES     = 2,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_empty,
  output logic                      o_rd_uart,
  output logic [7:0]                o_tx_data,
  output logic                      o_wr_uart,
  input  logic                      i_tx_full,
  output logic [8*DATA_BYTES-1:0]   o_alu_a,
  output logic [8*DATA_BYTES-1:0]   o_alu_b,
  output logic [NB_OP-1:0]          o_alu_op,
  input  logic [8*DATA_BYTES-1:0]   i_alu_result,
  input  logic                      i_alu_carry,
  output logic [8*DATA_BYTES-1:0]   o_result,
  output logic                      o_carry,
  output logic                      o_zero,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_frame_err
);

  localparam int NB_DATA = 8 * DATA_BYTES;
`ifdef STATUS_BYTE_EN
  localparam int TX_BYTES = DATA_BYTES + 1;
`else
  localparam int TX_BYTES = DATA_BYTES;
`endif
  localparam int NB_TX  = 8 * TX_BYTES;
  localparam int RX_TOP = NB_DATA - 8;
  localparam int IDX_W  = $clog2(TX_BYTES + 1);
  localparam int TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] RX_LAST = IDX_W'(DATA_BYTES - 1);
  localparam logic [IDX_W-1:0] TX_LAST = IDX_W'(TX_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

  typedef enum logic [2:0] {
    S_RX_A  = 3'd0,
    S_RX_B  = 3'd1,
    S_RX_OP = 3'd2,
    S_EXEC  = 3'd3,
    S_TX    = 3'd4
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_started;
  logic [NB_DATA-1:0] r_a_buf;
  logic [NB_DATA-1:0] r_b_buf;
  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_result;
  logic               r_carry;
  logic               r_zero;
  logic [NB_TX-1:0]   r_tx_shift;
  logic               r_done;
  logic               r_frame_err;

  logic w_in_rx;
  logic w_pop;
  logic w_push;
  logic w_timeout;
  logic w_res_zero;

  assign w_in_rx    = (r_state == S_RX_A) || (r_state == S_RX_B) || (r_state == S_RX_OP);
  // The FIFO is first-word fall-through, so the pop strobe must coincide with
  // the cycle the head byte is captured; it is decoded from registered state
  // and gated by reset so every output reads 0 while reset is held.
  assign w_pop      = i_reset_n && w_in_rx && !i_rx_empty;
  assign w_push     = i_reset_n && (r_state == S_TX) && !i_tx_full;
  // Expiry on the TIMEOUT_CYCLES-th idle cycle; a pop in that cycle wins.
  assign w_timeout  = (TIMEOUT_CYCLES > 0) && w_in_rx && r_started && !w_pop &&
                      (r_to_cnt == TO_LAST);
  assign w_res_zero = (i_alu_result == {NB_DATA{1'b0}});

  assign o_rd_uart   = w_pop;
  assign o_wr_uart   = w_push;
  assign o_tx_data   = r_tx_shift[7:0];
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_op    = r_alu_op;
  assign o_result    = r_result;
  assign o_carry     = r_carry;
  assign o_zero      = r_zero;
  assign o_busy      = !((r_state == S_RX_A) && (r_idx == {IDX_W{1'b0}}));
  assign o_done      = r_done;
  assign o_frame_err = r_frame_err;

  // Frame FSM: byte collection, EXEC latch, tx serialisation and timeout.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_RX_A;
      r_idx       <= {IDX_W{1'b0}};
      r_to_cnt    <= {TO_W{1'b0}};
      r_started   <= 1'b0;
      r_a_buf     <= {NB_DATA{1'b0}};
      r_b_buf     <= {NB_DATA{1'b0}};
      r_alu_a     <= {NB_DATA{1'b0}};
      r_alu_b     <= {NB_DATA{1'b0}};
      r_alu_op    <= {NB_OP{1'b0}};
      r_result    <= {NB_DATA{1'b0}};
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_tx_shift  <= {NB_TX{1'b0}};
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;

      // Idle counter only runs while a partially received frame is pending.
      if (w_pop || w_timeout) begin
        r_to_cnt <= {TO_W{1'b0}};
      end else if (w_in_rx && r_started && (TIMEOUT_CYCLES > 0)) begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end else begin
        r_to_cnt <= {TO_W{1'b0}};
      end

      if (w_timeout) begin
        // Partial operands are dropped; ALU-facing and result regs keep
        // their previous values.
        r_state     <= S_RX_A;
        r_idx       <= {IDX_W{1'b0}};
        r_started   <= 1'b0;
        r_frame_err <= 1'b1;
      end else begin
        case (r_state)
          S_RX_A: begin
            if (w_pop) begin
              // Little-endian: bytes enter at the top and shift down, so the
              // first byte ends in the LSB after DATA_BYTES pops.
              r_a_buf   <= (r_a_buf >> 8) | (NB_DATA'(i_rx_data) << RX_TOP);
              r_started <= 1'b1;
              if (r_idx == RX_LAST) begin
                r_idx   <= {IDX_W{1'b0}};
                r_state <= S_RX_B;
              end else begin
                r_idx   <= r_idx + IDX_ONE;
              end
            end
          end
          S_RX_B: begin
            if (w_pop) begin
              r_b_buf   <= (r_b_buf >> 8) | (NB_DATA'(i_rx_data) << RX_TOP);
              r_started <= 1'b1;
              if (r_idx == RX_LAST) begin
                r_idx   <= {IDX_W{1'b0}};
                r_state <= S_RX_OP;
              end else begin
                r_idx   <= r_idx + IDX_ONE;
              end
            end
          end
          S_RX_OP: begin
            if (w_pop) begin
              // Operands reach the ALU only once the frame is complete.
              r_alu_a   <= r_a_buf;
              r_alu_b   <= r_b_buf;
              r_alu_op  <= i_rx_data[NB_OP-1:0];
              r_started <= 1'b0;
              r_idx     <= {IDX_W{1'b0}};
              r_state   <= S_EXEC;
            end
          end
          S_EXEC: begin
            r_result <= i_alu_result;
            r_carry  <= i_alu_carry;
            r_zero   <= w_res_zero;
`ifdef STATUS_BYTE_EN
            r_tx_shift <= {6'b000000, w_res_zero, i_alu_carry, i_alu_result};
`else
            r_tx_shift <= i_alu_result;
`endif
            r_idx    <= {IDX_W{1'b0}};
            r_state  <= S_TX;
          end
          S_TX: begin
            if (w_push) begin
              r_tx_shift <= r_tx_shift >> 8;
              if (r_idx == TX_LAST) begin
                r_idx   <= {IDX_W{1'b0}};
                r_done  <= 1'b1;
                r_state <= S_RX_A;
              end else begin
                r_idx   <= r_idx + IDX_ONE;
              end
            end
          end
          default: begin
            r_state   <= S_RX_A;
            r_idx     <= {IDX_W{1'b0}};
            r_started <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_frame_ctrl
//   Scoreboard bench for alu_uart_frame_ctrl (DATA_BYTES=2). Frames are issued
//   into an rx FIFO model; the expected tx bytes and flags are computed from
//   integer arithmetic and queued. A monitor compares each tx push and each
//   o_done pulse against the queues. A small ALU model answers the DUT.
// -----------------------------------------------------------------------------
module tb_alu_uart_frame_ctrl;

  localparam int DB  = 2;
  localparam int NBD = 8 * DB;
  localparam int TO  = 1000;
`ifdef STATUS_BYTE_EN
  localparam int TXB = DB + 1;
`else
  localparam int TXB = DB;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_empty = 1'b1;
  logic           rd_uart;
  logic [7:0]     tx_data;
  logic           wr_uart;
  logic           tx_full = 1'b0;
  logic [NBD-1:0] alu_a, alu_b, alu_r, result;
  logic [5:0]     alu_op;
  logic           alu_c, carry, zero, busy, done, frame_err;

  alu_uart_frame_ctrl #(.DATA_BYTES(DB), .NB_OP(6), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_rx_data(rx_data), .i_rx_empty(rx_empty), .o_rd_uart(rd_uart),
    .o_tx_data(tx_data), .o_wr_uart(wr_uart), .i_tx_full(tx_full),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_result(alu_r), .i_alu_carry(alu_c),
    .o_result(result), .o_carry(carry), .o_zero(zero),
    .o_busy(busy), .o_done(done), .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // ALU answering the DUT: 20 ADD, 22 SUB (carry = borrow), 24 AND, 25 OR, 26 XOR, else A
  always_comb begin
    case (alu_op)
      6'h20:   {alu_c, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
      6'h22:   {alu_c, alu_r} = {1'b0, alu_a} - {1'b0, alu_b};
      6'h24:   {alu_c, alu_r} = {1'b0, alu_a & alu_b};
      6'h25:   {alu_c, alu_r} = {1'b0, alu_a | alu_b};
      6'h26:   {alu_c, alu_r} = {1'b0, alu_a ^ alu_b};
      default: {alu_c, alu_r} = {1'b0, alu_a};
    endcase
  end

  logic [7:0]     rxq[$];
  logic [7:0]     expq[$];
  logic [NBD+1:0] flagq[$];   // {zero, carry, result}

  int compared = 0, mismatched = 0;
  int cyc = 0, last_pop_cyc = 0, ferr_cyc = 0;
  int push_cnt = 0, pop_cnt = 0, done_cnt = 0, ferr_cnt = 0, tx_idx = 0;
  bit force_full = 1'b0, rand_full = 1'b0, lat_chk = 1'b0, ferr_allowed = 1'b0;
  bit rd_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic on the whole operands.
  task automatic issue_frame(input int a, input int b, input logic [7:0] opb, input int maxgap);
    int res, c, op;
    logic [7:0] fb[5];
    op = int'(opb) % 64;
    c  = 0;
    case (op)
      32: begin res = (a + b) % 65536; c = ((a + b) >= 65536) ? 1 : 0; end
      34: begin res = (a - b + 65536) % 65536; c = (a < b) ? 1 : 0; end
      36: res = a & b;
      37: res = a | b;
      38: res = a ^ b;
      default: res = a;
    endcase
    for (int i = 0; i < DB; i++) expq.push_back(8'((res >> (8 * i)) % 256));
`ifdef STATUS_BYTE_EN
    expq.push_back(8'((res == 0 ? 2 : 0) + c));
`endif
    flagq.push_back({(res == 0), 1'(c), 16'(res)});
    fb[0] = 8'(a % 256); fb[1] = 8'(a / 256);
    fb[2] = 8'(b % 256); fb[3] = 8'(b / 256);
    fb[4] = opb;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      @(negedge clk);
      rxq.push_back(fb[i]);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 3000 && !(expq.size() == 0 && flagq.size() == 0 && rxq.size() == 0 && busy == 1'b0)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_bound"}, 32'(n < 3000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // rx/tx FIFO model: pops on the strobe seen in the cycle, refreshes head/full
  always begin
    @(negedge clk);
    rd_seen = rd_uart;
    @(posedge clk);
    #1;
    if (rd_seen) begin
      if (rxq.size() > 0) begin
        void'(rxq.pop_front());
        pop_cnt++;
      end else begin
        check("pop_on_empty", 32'd1, 32'd0);
      end
    end
    tx_full  = force_full || (rand_full && ($urandom_range(0, 3) == 0));
    rx_empty = (rxq.size() == 0);
    rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  // Monitor: compares every push and done pulse against the scoreboard
  always @(negedge clk) begin
    logic [7:0]     eb;
    logic [NBD+1:0] ef;
    cyc++;
    if (!rst_n) begin
      tx_idx = 0;
    end else begin
      if (rd_uart) last_pop_cyc = cyc;
      if (wr_uart) begin
        check("push_while_full", 32'(tx_full), 32'd0);
        push_cnt++;
        if (expq.size() == 0) begin
          check("tx_unexpected_push", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          eb = expq.pop_front();
          check("tx_byte", 32'(tx_data), 32'(eb));
          if (lat_chk && tx_idx == 0) check("pop_to_push_latency", 32'(cyc - last_pop_cyc), 32'd2);
        end
        tx_idx = (tx_idx + 1) % TXB;
      end
      if (done) begin
        done_cnt++;
        check("done_after_last_byte", 32'(tx_idx), 32'd0);
        if (flagq.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          ef = flagq.pop_front();
          check("result", 32'(result), 32'(ef[NBD-1:0]));
          check("carry", 32'(carry), 32'(ef[NBD]));
          check("zero", 32'(zero), 32'(ef[NBD+1]));
        end
      end
      if (frame_err) begin
        ferr_cnt++;
        ferr_cyc = cyc;
        check("frame_err_allowed", 32'(ferr_allowed), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0, f0, n;
    logic [NBD-1:0] keep_res, keep_a;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({rd_uart, tx_data, wr_uart, alu_a, alu_b, alu_op}), 32'd0);
    check("reset_flags", 32'({result, carry, zero, busy, done, frame_err}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 0x1234 + 0x0001 -> 0x1235, latency 2
    p0 = pop_cnt; d0 = done_cnt; lat_chk = 1'b1;
    issue_frame(32'h1234, 32'h0001, 8'h20, 0);
    wait_idle("t1");
    lat_chk = 1'b0;
    check("t1_pops", 32'(pop_cnt - p0), 32'd5);
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);

    // 2: 0xFFFF + 1 wraps to zero with carry; opcode upper bits ignored
    issue_frame(32'hFFFF, 32'h0001, 8'h20, 0);
    wait_idle("t2");
    issue_frame(32'h8001, 32'h0002, 8'hE2, 1);
    wait_idle("t2b");

    // 3: tx held full on TX entry
    force_full = 1'b1;
    p0 = push_cnt;
    issue_frame(32'h0F0F, 32'h00FF, 8'h24, 0);
    repeat (20) @(negedge clk);
    check("t3_no_push_while_full", 32'(push_cnt - p0), 32'd0);
    force_full = 1'b0;
    wait_idle("t3");

    // 4: partial frame then idle -> discard after TIMEOUT_CYCLES
    keep_res = result; keep_a = alu_a; p0 = push_cnt; f0 = ferr_cnt; d0 = done_cnt;
    ferr_allowed = 1'b1;
    @(negedge clk); rxq.push_back(8'h34);
    @(negedge clk); rxq.push_back(8'h12);
    @(negedge clk); rxq.push_back(8'h56);
    n = 0;
    while (ferr_cnt == f0 && n < TO + 200) begin @(negedge clk); n++; end
    ferr_allowed = 1'b0;
    check("t4_frame_err_once", 32'(ferr_cnt - f0), 32'd1);
    check("t4_timeout_cycles", 32'(ferr_cyc - last_pop_cyc), 32'(TO + 1));
    check("t4_result_kept", 32'(result), 32'(keep_res));
    check("t4_alu_a_kept", 32'(alu_a), 32'(keep_a));
    check("t4_no_tx", 32'(push_cnt - p0), 32'd0);
    check("t4_not_busy", 32'(busy), 32'd0);
    issue_frame(32'h1234, 32'h0001, 8'h22, 0);
    wait_idle("t4_fresh");
    check("t4_one_done", 32'(done_cnt - d0), 32'd1);

    // 5: reset during TX after the first byte
    p0 = push_cnt; d0 = done_cnt;
    issue_frame(32'hBEEF, 32'h1111, 8'h20, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_uart && n < 200);
    check("t5_first_push_bound", 32'(n < 200), 32'd1);
    force_full = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_reset_outputs", 32'({rd_uart, tx_data, wr_uart, alu_a, alu_op}), 32'd0);
    check("t5_reset_flags", 32'({alu_b, result, carry, zero, busy, done, frame_err}), 32'd0);
    expq.delete();
    flagq.delete();
    force_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_single_push", 32'(push_cnt - p0), 32'd1);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_idle_rx_a", 32'(busy), 32'd0);

    // Randomised frames with random gaps and tx back-pressure
    rand_full = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 25; k++) begin
      logic [7:0] opb;
      case ($urandom_range(0, 5))
        0: opb = 8'h20;
        1: opb = 8'h22;
        2: opb = 8'h24;
        3: opb = 8'h25;
        4: opb = 8'h26;
        default: opb = 8'($urandom_range(0, 255));
      endcase
      opb[7:6] = 2'($urandom_range(0, 3));
      issue_frame(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), opb, 3);
    end
    wait_idle("rand");
    rand_full = 1'b0;
    check("rand_done_count", 32'(done_cnt - d0), 32'd25);
    check("scoreboard_empty", 32'(expq.size() + flagq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
